// File: rtl/mac_seq_pkg.sv
// Shared definitions for the MAC array sequencer.
//   state_t     : sequencer state encoding
//   *_DEF       : default values for N, TILES and TIMEOUT
//   idx_width() : clog2 of a count, never narrower than 1 bit
package mac_seq_pkg;

  localparam int unsigned N_DEF       = 4;
  localparam int unsigned TILES_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_A,
    S_START_C,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  function automatic int unsigned idx_width(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive enabled cycles and flags the TIMEOUT-th one.
//   clk, rst : clock and synchronous active-high reset
//   clear    : restart the count at 0
//   enable   : count this cycle
//   expired  : high during the TIMEOUT-th consecutive enabled cycle
module wait_timer
  import mac_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned   CW   = idx_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Holds at LAST so a stalled enable cannot wrap back into a fresh window.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mac_array_seq.sv
// Job sequencer for an NxN systolic MAC array: loads N weight rows (unless
// still valid and reuse is requested), then for each of TILES A tiles loads
// N rows, kicks the compute and waits for the output collector.
//   CLK, RST              : clock, synchronous active-high reset
//   ext_start, w_reuse    : job request, skip weight load if weights valid
//   abort                 : cancel the job from any busy state
//   row_done_from_output  : tile-complete pulse from the output collector
//   W_LOAD/WROW           : weight-row write strobe and row index
//   LOAD_EN/IDST/ODST     : A-row write strobe, row index, tile index
//   START_CALC            : one-cycle compute kick
//   BUSY/System_Done/ERR  : status
// All outputs decode from registered state and counters only.
module mac_array_seq
  import mac_seq_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned TILES   = TILES_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          ext_start,
  input  logic                          w_reuse,
  input  logic                          abort,
  input  logic                          row_done_from_output,
  output logic                          W_LOAD,
  output logic [idx_width(N)-1:0]       WROW,
  output logic                          LOAD_EN,
  output logic [idx_width(N)-1:0]       IDST,
  output logic [idx_width(TILES)-1:0]   ODST,
  output logic                          START_CALC,
  output logic                          BUSY,
  output logic                          System_Done,
  output logic                          ERR
);

  localparam int unsigned ROW_W  = idx_width(N);
  localparam int unsigned TILE_W = idx_width(TILES);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(N - 1);
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(TILES - 1);

  state_t             state, state_next;
  logic [ROW_W-1:0]   row, row_next;
  logic [TILE_W-1:0]  tile, tile_next;
  logic               w_valid, w_valid_next;
  logic               timer_expired;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (CLK),
    .rst     (RST),
    .clear   (state != S_WAIT),
    .enable  (state == S_WAIT),
    .expired (timer_expired)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      row     <= '0;
      tile    <= '0;
      w_valid <= 1'b0;
    end else begin
      state   <= state_next;
      row     <= row_next;
      tile    <= tile_next;
      w_valid <= w_valid_next;
    end
  end

  always_comb begin
    state_next   = state;
    row_next     = row;
    tile_next    = tile;
    w_valid_next = w_valid;

    case (state)
      S_IDLE: begin
        row_next  = '0;
        tile_next = '0;
        if (ext_start) begin
          state_next = (w_reuse && w_valid) ? S_LOAD_A : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (row == ROW_LAST) begin
          row_next     = '0;
          tile_next    = '0;
          w_valid_next = 1'b1;
          state_next   = S_LOAD_A;
        end else begin
          row_next = row + ROW_W'(1);
        end
      end
      S_LOAD_A: begin
        if (row == ROW_LAST) begin
          row_next   = '0;
          state_next = S_START_C;
        end else begin
          row_next = row + ROW_W'(1);
        end
      end
      S_START_C: state_next = S_WAIT;
      S_WAIT: begin
        // A completion in the same cycle as expiry still counts as completion.
        if (row_done_from_output) begin
          if (tile == TILE_LAST) begin
            state_next = S_DONE;
          end else begin
            tile_next  = tile + TILE_W'(1);
            state_next = S_LOAD_A;
          end
        end else if (timer_expired) begin
          w_valid_next = 1'b0;
          state_next   = S_ERROR;
        end
      end
      S_DONE: begin
        tile_next  = '0;
        state_next = S_IDLE;
      end
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_IDLE;
    endcase

    // A partially written weight set must not be reused.
    if (abort && (state != S_IDLE)) begin
      state_next   = S_IDLE;
      row_next     = '0;
      tile_next    = '0;
      w_valid_next = (state == S_LOAD_W) ? 1'b0 : w_valid;
    end
  end

  always_comb begin
    W_LOAD      = (state == S_LOAD_W);
    LOAD_EN     = (state == S_LOAD_A);
    START_CALC  = (state == S_START_C);
    BUSY        = (state != S_IDLE);
    System_Done = (state == S_DONE);
    ERR         = (state == S_ERROR);
    WROW        = W_LOAD ? row : '0;
    IDST        = LOAD_EN ? row : '0;
    ODST        = (LOAD_EN || START_CALC) ? tile : '0;
  end

endmodule
